ibex_fp_wb_arbiter: RTL
=======================

# ibex_fp_wb_arbiter

Write-side front end for the FP register file: merges results from the FPU pipeline and FP loads (FLW) from the LSU onto the single register-file write port (waddr/wdata/we). LSU writes are buffered in a small FIFO. FPU results take priority, with ordering protection and a starvation guard. The block also exports a pending-write bitmap so decode can stall FP reads until the matching write has landed.

## Interface
Parameters:
- DataWidth, 32, width of FP register data
- FifoDepth, 2, LSU write buffer entries (2..4)
- StarveLimit, 4, consecutive blocked cycles before the FIFO head is forced out (1..15)

Ports:
- clk_i  in  1  clock; single clock domain, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- fpu_valid_i  in  1  FPU result valid
- fpu_waddr_i  in  5  FPU destination register
- fpu_wdata_i  in  DataWidth  FPU result
- fpu_ready_o  out  1  FPU result accepted this cycle (combinational)
- lsu_valid_i  in  1  FP load data valid
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DataWidth  load data
- lsu_ready_o  out  1  load accepted this cycle (combinational)
- fp_waddr_a_o  out  5  register-file write address (registered)
- fp_wdata_a_o  out  DataWidth  register-file write data (registered)
- fp_we_a_o  out  1  register-file write enable (registered)
- pend_o  out  32  bit r set while an accepted write to r has not yet reached the register file

## Operation
- Transfers complete when valid and ready are both high in the same cycle. Inputs need not hold once accepted.
- Ordering rule: an LSU write is older than any FPU write presented in the same or a later cycle.
- Each cycle selects at most one source for the output stage, in this priority order:
  1. Forced pop: the starvation counter equals StarveLimit and the FIFO is non-empty. The FIFO head goes out and fpu_ready_o=0.
  2. Hazard: fpu_valid_i with fpu_waddr_i matching any valid FIFO entry, or matching lsu_waddr_i while lsu_valid_i is high. The FIFO head goes out, or the LSU input is bypassed if the FIFO is empty. fpu_ready_o=0.
  3. FPU: fpu_valid_i is high. The FPU result goes out and fpu_ready_o=1.
  4. FIFO head, if the FIFO is non-empty.
  5. Bypass: the FIFO is empty and lsu_valid_i is high. The LSU input goes directly to the output stage without being pushed.
- Otherwise fpu_ready_o=1 when no other rule applies.
- lsu_ready_o = FIFO not full. This includes the full case, even when a pop occurs in the same cycle; there is no same-cycle pop/push pass-through when full.
- An accepted LSU write is pushed into the FIFO unless it was bypassed. Push and pop may happen in the same cycle.
- Starvation counter (4 bits):
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at StarveLimit.
- Address 0: the write is accepted and sequenced normally but fp_we_a_o stays 0 for it, and it never sets pend_o[0]. This matches the register file, which ignores f0 writes.
- pend_o is combinational:
  - OR of decoded addresses of valid FIFO entries, plus the output-stage address when fp_we_a_o=1.
  - Bit 0 is forced 0.

## Timing
- Output stage latency 1 cycle: a source selected in cycle N drives fp_*_o in cycle N+1. The register file writes on the edge ending N+1.
- FPU path latency 1. LSU bypass latency 1. LSU buffered latency is at least 2.
- pend_o[r] rises in the cycle after acceptance and falls in the cycle after the last write to r leaves the output stage.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFO emptied, contents discarded; starvation counter 0.
  - fp_we_a_o=0, fp_waddr_a_o=0, fp_wdata_a_o=0, pend_o=0.
  - lsu_ready_o=1 and fpu_ready_o=1 while no hazard or forced pop applies.
- FIFO pointers wrap modulo FifoDepth. Occupancy is tracked by a separate counter (0..FifoDepth), so full and empty are unambiguous.

## Test plan
- FPU only: fpu_valid_i=1, waddr=5, wdata=0x3F800000 -> next cycle fp_we_a_o=1, fp_waddr_a_o=5, fp_wdata_a_o=0x3F800000; pend_o=0x20 for that one cycle.
- LSU bypass: FIFO empty, lsu write to f7=0x40490FDB -> out in 1 cycle; with fpu_valid_i also high to f3, the LSU entry is pushed and written in the cycle after the FPU write.
- Ordering hazard: LSU to f9 queued, FPU to f9 presented -> fpu_ready_o=0 until the LSU f9 write is popped. Output order is LSU f9 then FPU f9, and the final value is the FPU data.
- Starvation: FPU valid every cycle to f1, with FifoDepth=2 and StarveLimit=4, LSU fills the FIFO -> lsu_ready_o=0 when full. The head is forced out after 4 blocked cycles, with fpu_ready_o=0 in exactly that cycle.
- f0 writes: FPU and LSU writes to f0 -> accepted, fp_we_a_o never 1, pend_o[0]=0.
- Reset mid-operation: with 2 FIFO entries and the output stage valid, assert rst_i between edges -> all outputs 0 immediately. After release, no stale writes appear.

Source files
------------

// File: rtl/ibex_fp_wb_arbiter.sv
// FP register-file write arbiter.
// Merges FPU results and buffered FP loads onto a single write port.
// FPU results win unless a queued load to the same register must land first,
// or the load buffer has been starved too long. pend_o tracks in-flight writes
// so decode can hold FP reads.
module ibex_fp_wb_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fpu_valid_i,
  input  logic [4:0]           fpu_waddr_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  output logic                 fpu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic [4:0]           fp_waddr_a_o,
  output logic [DataWidth-1:0] fp_wdata_a_o,
  output logic                 fp_we_a_o,
  output logic [31:0]          pend_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam logic [3:0]      StarveMax = 4'(StarveLimit);
  localparam logic [CntW-1:0] CntFull   = CntW'(FifoDepth);
  localparam logic [PtrW-1:0] PtrLast   = PtrW'(FifoDepth - 1);

  // Source feeding the output stage this cycle.
  typedef enum logic [1:0] {
    SrcNone,
    SrcHead,
    SrcLsu,
    SrcFpu
  } src_e;

  // LSU write buffer.
  logic [4:0]           r_fifo_addr [FifoDepth];
  logic [DataWidth-1:0] r_fifo_data [FifoDepth];
  logic [FifoDepth-1:0] r_fifo_vld;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [CntW-1:0]      r_count;
  logic [3:0]           r_starve;

  // Output stage.
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DataWidth-1:0] r_wdata;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_force;
  logic                 w_fifo_hit;
  logic                 w_hazard;
  logic                 w_lsu_acc;
  logic                 w_pop;
  logic                 w_push;
  src_e                 w_sel;
  logic [4:0]           w_sel_addr;
  logic [DataWidth-1:0] w_sel_data;
  logic [31:0]          w_pend;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CntFull);
  assign w_force   = (r_starve == StarveMax) && !w_empty;
  assign w_hazard  = fpu_valid_i &&
                     (w_fifo_hit || (lsu_valid_i && (lsu_waddr_i == fpu_waddr_i)));
  assign w_lsu_acc = lsu_valid_i && !w_full;
  assign w_pop     = (w_sel == SrcHead);
  assign w_push    = w_lsu_acc && (w_sel != SrcLsu);

  // Detect an FPU destination that collides with a queued load.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_fifo_hit = 1'b0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (r_fifo_vld[i] && (r_fifo_addr[i] == fpu_waddr_i)) w_fifo_hit = 1'b1;
    end
  end

  // Priority selection: forced pop, hazard drain, FPU, FIFO head, bypass.
  always_comb begin
    w_sel = SrcNone;
    if (w_force)               w_sel = SrcHead;
    else if (w_hazard)         w_sel = w_empty ? SrcLsu : SrcHead;
    else if (fpu_valid_i)      w_sel = SrcFpu;
    else if (!w_empty)         w_sel = SrcHead;
    else if (lsu_valid_i)      w_sel = SrcLsu;
  end

  // Mux the chosen source's address and data.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    unique case (w_sel)
      SrcHead: begin
        w_sel_addr = r_fifo_addr[r_rd_ptr];
        w_sel_data = r_fifo_data[r_rd_ptr];
      end
      SrcLsu: begin
        w_sel_addr = lsu_waddr_i;
        w_sel_data = lsu_wdata_i;
      end
      SrcFpu: begin
        w_sel_addr = fpu_waddr_i;
        w_sel_data = fpu_wdata_i;
      end
      default: ;
    endcase
  end

  // FIFO control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fifo_vld <= '0;
    end else begin
      if (w_pop) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrW'(1);
      end
      if (w_push) begin
        r_fifo_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: ;
      endcase
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk_i) begin
    // NOTE: payload storage has no reset; the valid bits alone decide what is meaningful.
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= lsu_waddr_i;
      r_fifo_data[r_wr_ptr] <= lsu_wdata_i;
    end
  end

  // Starvation counter: counts consecutive cycles a non-empty FIFO is not popped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (r_starve != StarveMax) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Output stage register; f0 writes are sequenced but never enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_sel != SrcNone) begin
      r_we    <= (w_sel_addr != 5'd0);
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Pending bitmap: queued loads plus the write currently in the output stage.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (r_fifo_vld[i]) w_pend[r_fifo_addr[i]] = 1'b1;
    end
    if (r_we) w_pend[r_waddr] = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign fpu_ready_o  = !(w_force || w_hazard);
  assign lsu_ready_o  = !w_full;
  assign fp_we_a_o    = r_we;
  assign fp_waddr_a_o = r_waddr;
  assign fp_wdata_a_o = r_wdata;
  assign pend_o       = w_pend;

endmodule
